// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter
//   Shares one sin/cos CORDIC core between N_REQ requesters. Requests are
//   granted round-robin and the winning phase is issued to the core one cycle
//   later. The winner's index goes into an in-order tag FIFO, and each sin/cos
//   result is returned to the requester at the head of that FIFO.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   MAX_OUT  maximum in-flight CORDIC ops, tag FIFO depth (power of 2)
//   DATA_W   width of phase, sin and cos words
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   arb_en               1 = grant requests, 0 = stop granting and drain
//   req_valid/req_phase  per-requester request, phase i at [i*DATA_W +: DATA_W]
//   req_ready            combinational one-hot accept
//   phase_tdata/tvalid   phase stream to the CORDIC core
//   sin_*/cos_*          result streams from the CORDIC core (no backpressure)
//   rsp_valid            one-hot 1-cycle pulse to the owning requester
//   rsp_sin/rsp_cos      result data, valid with rsp_valid
//   busy                 FSM not idle or ops outstanding
//   drain_done           1-cycle pulse on DRAIN -> IDLE
//   err_orphan           sticky: result arrived with the tag FIFO empty
//   err_mismatch         sticky: sin_tvalid and cos_tvalid disagreed
//
// Configuration
//   ARB_FIXED_PRIO_EN    when defined, the lowest set req_valid index wins and
//                        no round-robin pointer exists; default is round-robin.

module cordic_share_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_en,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_phase,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         phase_tdata,
    output logic                      phase_tvalid,
    input  logic [DATA_W-1:0]         sin_tdata,
    input  logic                      sin_tvalid,
    input  logic [DATA_W-1:0]         cos_tdata,
    input  logic                      cos_tvalid,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_sin,
    output logic [DATA_W-1:0]         rsp_cos,
    output logic                      busy,
    output logic                      drain_done,
    output logic                      err_orphan,
    output logic                      err_mismatch
);

    localparam int unsigned TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [TAG_W-1:0]  tag_mem [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              fifo_empty;
    logic              fifo_full;
    logic              result_both;
    logic              result_any;
    logic              push;
    logic              pop;
    logic              grant;
    logic [TAG_W-1:0]  winner;
    logic [DATA_W-1:0] winner_phase;
    logic [TAG_W-1:0]  head_tag;
    logic [N_REQ-1:0]  head_onehot;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CNT_W'(MAX_OUT));
    assign result_both = sin_tvalid && cos_tvalid;
    assign result_any  = sin_tvalid || cos_tvalid;
    assign push        = grant;
    assign pop         = result_both && !fifo_empty;
    assign head_tag    = tag_mem[rd_ptr];
    assign busy        = (state != S_IDLE) || (count != '0);

    // ------------------------------------------------------------------
    // Arbitration. Capacity is judged on the registered count, so a pop in
    // the same cycle never opens a slot for that cycle's grant.
    // ------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        if (!rst && state == S_RUN && !fifo_full) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!grant && req_valid[i]) begin
                    grant  = 1'b1;
                    winner = TAG_W'(i);
                end
            end
        end
    end
`else
    localparam int unsigned SUM_W = TAG_W + 1;

    logic [TAG_W-1:0] rr_ptr;
    logic [SUM_W-1:0] rr_sum;

    // Scan N_REQ candidates starting at rr_ptr, wrapping modulo N_REQ
    // without a divider (N_REQ need not be a power of 2).
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        rr_sum = '0;
        if (!rst && state == S_RUN && !fifo_full) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                rr_sum = {1'b0, rr_ptr} + SUM_W'(k);
                if (rr_sum >= SUM_W'(N_REQ)) begin
                    rr_sum = rr_sum - SUM_W'(N_REQ);
                end
                if (!grant && req_valid[rr_sum[TAG_W-1:0]]) begin
                    grant  = 1'b1;
                    winner = rr_sum[TAG_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (winner == TAG_W'(N_REQ - 1)) ? '0 : winner + TAG_W'(1);
        end
    end
`endif

    always_comb begin
        req_ready    = '0;
        winner_phase = '0;
        head_onehot  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i]   = grant && (winner == TAG_W'(i));
            head_onehot[i] = (head_tag == TAG_W'(i));
            if (winner == TAG_W'(i)) begin
                winner_phase = req_phase[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        drain_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_en) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!arb_en) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (arb_en) begin
                    state_next = S_RUN;
                end else if (fifo_empty && !result_any) begin
                    state_next = S_IDLE;
                    drain_done = !rst;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue stage: winner's phase goes out the cycle after the grant
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_tvalid <= 1'b0;
            phase_tdata  <= '0;
        end else begin
            phase_tvalid <= grant;
            if (grant) begin
                phase_tdata <= winner_phase;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing and error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_sin   <= '0;
            rsp_cos   <= '0;
        end else begin
            rsp_valid <= pop ? head_onehot : '0;
            if (pop) begin
                rsp_sin <= sin_tdata;
                rsp_cos <= cos_tdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_orphan   <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            if (result_both && fifo_empty) begin
                err_orphan <= 1'b1;
            end
            if (sin_tvalid != cos_tvalid) begin
                err_mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Self-checking bench for cordic_share_arbiter: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.

module tb_cordic_share_arbiter;

    localparam int N  = 4;
    localparam int MO = 4;
    localparam int DW = 32;
    localparam logic [DW-1:0] SIN_KEY = 32'h5A5A_0F0F;

    logic            clk = 1'b0;
    logic            rst;
    logic            arb_en;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_phase;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   phase_tdata;
    logic            phase_tvalid;
    logic [DW-1:0]   sin_tdata;
    logic            sin_tvalid;
    logic [DW-1:0]   cos_tdata;
    logic            cos_tvalid;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_sin;
    logic [DW-1:0]   rsp_cos;
    logic            busy;
    logic            drain_done;
    logic            err_orphan;
    logic            err_mismatch;

    cordic_share_arbiter #(
        .N_REQ   (N),
        .MAX_OUT (MO),
        .DATA_W  (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_phase    (req_phase),
        .req_ready    (req_ready),
        .phase_tdata  (phase_tdata),
        .phase_tvalid (phase_tvalid),
        .sin_tdata    (sin_tdata),
        .sin_tvalid   (sin_tvalid),
        .cos_tdata    (cos_tdata),
        .cos_tvalid   (cos_tvalid),
        .rsp_valid    (rsp_valid),
        .rsp_sin      (rsp_sin),
        .rsp_cos      (rsp_cos),
        .busy         (busy),
        .drain_done   (drain_done),
        .err_orphan   (err_orphan),
        .err_mismatch (err_mismatch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=idle 1=run 2=drain; tagq holds owners in issue order
    int            m_state;
    int            tagq[$];
    int            m_rr;
    int            m_win;
    logic [N-1:0]  exp_ready;
    logic          exp_busy;
    logic          exp_drain;
    logic          exp_ptv;
    logic [DW-1:0] exp_ptd;
    logic [N-1:0]  exp_rsp_valid;
    logic [DW-1:0] exp_rsp_sin;
    logic [DW-1:0] exp_rsp_cos;
    logic          exp_orphan;
    logic          exp_mismatch;

    logic [N-1:0]  obs_ready;
    logic          obs_busy;
    logic          obs_drain;

    // CORDIC stand-in: result appears 3 cycles after the phase beat
    bit            cordic_on;
    logic          cv[4];
    logic [DW-1:0] cd[4];

    task automatic model_eval();
        exp_ready = '0;
        m_win     = -1;
        if (!rst && m_state == 1 && tagq.size() < MO) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (m_win < 0 && req_valid[i]) m_win = i;
            end
        end
        if (m_win >= 0) exp_ready[m_win] = 1'b1;
        exp_busy  = (m_state != 0) || (tagq.size() != 0);
        exp_drain = !rst && m_state == 2 && !arb_en && tagq.size() == 0
                    && !(sin_tvalid || cos_tvalid);
    endtask

    task automatic model_commit();
        int pre;
        if (rst) begin
            tagq.delete();
            m_state       = 0;
            m_rr          = 0;
            exp_ptv       = 1'b0;
            exp_ptd       = '0;
            exp_rsp_valid = '0;
            exp_rsp_sin   = '0;
            exp_rsp_cos   = '0;
            exp_orphan    = 1'b0;
            exp_mismatch  = 1'b0;
            return;
        end
        pre = tagq.size();
        exp_ptv = (m_win >= 0);
        if (m_win >= 0) exp_ptd = req_phase[m_win*DW +: DW];
        exp_rsp_valid = '0;
        if (sin_tvalid && cos_tvalid) begin
            if (pre > 0) begin
                int t;
                t = tagq.pop_front();
                exp_rsp_valid[t] = 1'b1;
                exp_rsp_sin      = sin_tdata;
                exp_rsp_cos      = cos_tdata;
            end else begin
                exp_orphan = 1'b1;
            end
        end
        if (sin_tvalid != cos_tvalid) exp_mismatch = 1'b1;
        if (m_win >= 0) begin
            tagq.push_back(m_win);
            m_rr = (m_win + 1) % N;
        end
        case (m_state)
            0:       if (arb_en) m_state = 1;
            1:       if (!arb_en) m_state = 2;
            default: if (arb_en) m_state = 1; else if (exp_drain) m_state = 0;
        endcase
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        for (int i = 3; i > 0; i--) begin
            cv[i] = cv[i-1];
            cd[i] = cd[i-1];
        end
        cv[0] = phase_tvalid;
        cd[0] = phase_tdata;
        if (cordic_on) begin
            sin_tvalid = cv[3];
            cos_tvalid = cv[3];
            sin_tdata  = cd[3] ^ SIN_KEY;
            cos_tdata  = ~cd[3];
        end
        #1;
        obs_ready = req_ready;
        obs_busy  = busy;
        obs_drain = drain_done;
        model_eval();
        model_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_phases();
        for (int i = 0; i < N; i++) req_phase[i*DW +: DW] = $urandom;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        arb_en     = 1'b0;
        req_valid  = '0;
        sin_tvalid = 1'b0;
        cos_tvalid = 1'b0;
        sin_tdata  = '0;
        cos_tdata  = '0;
        cordic_on  = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cv[i] = 1'b0;
            cd[i] = '0;
        end
    endtask

    task automatic test_reset();
        req_phase = '0;
        do_reset();
        cycle();
        checks++;
        if ({phase_tvalid, rsp_valid, obs_ready} !== '0) begin
            errors++;
            $display("FAIL reset_valids: got %b required 0", {phase_tvalid, rsp_valid, obs_ready});
        end
        checks++;
        if ({phase_tdata, rsp_sin, rsp_cos} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h required 0", phase_tdata, rsp_sin, rsp_cos);
        end
        checks++;
        if ({obs_busy, obs_drain, err_orphan, err_mismatch} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got %b required 0000",
                     {obs_busy, obs_drain, err_orphan, err_mismatch});
        end
    endtask

    task automatic test_single();
        int seen;
        seen = 0;
        do_reset();
        cordic_on = 1'b1;
        arb_en    = 1'b1;
        cycle();
        rand_phases();
        req_phase[2*DW +: DW] = 32'h2000_0000;
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        checks++;
        if (obs_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b required 0100", obs_ready);
        end
        checks++;
        if (phase_tvalid !== 1'b1 || phase_tdata !== 32'h2000_0000) begin
            errors++;
            $display("FAIL single_issue: got v=%b d=%h required v=1 d=20000000", phase_tvalid, phase_tdata);
        end
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (c == 0) begin
                checks++;
                if (phase_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_issue_pulse: got %b required 0", phase_tvalid);
                end
            end
            checks++;
            if (rsp_valid !== exp_rsp_valid) begin
                errors++;
                $display("FAIL single_rsp_valid cycle %0d: got %b required %b", c, rsp_valid, exp_rsp_valid);
            end
            if (rsp_valid !== '0) begin
                seen++;
                checks++;
                if (rsp_valid !== 4'b0100 || rsp_sin !== (32'h2000_0000 ^ SIN_KEY) || rsp_cos !== ~32'h2000_0000) begin
                    errors++;
                    $display("FAIL single_rsp_data: got %b %h %h required 0100 %h %h", rsp_valid, rsp_sin,
                             rsp_cos, 32'h2000_0000 ^ SIN_KEY, ~32'h2000_0000);
                end
            end
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL single_rsp_count: got %0d required 1", seen);
        end
    endtask

    task automatic test_all_four();
        int gq[$];
        int rq[$];
        do_reset();
        cordic_on = 1'b1;
        arb_en    = 1'b1;
        req_valid = '1;
        rand_phases();
        cycle();
        for (int c = 0; c < 20; c++) begin
            rand_phases();
            cycle();
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL all4_ready cycle %0d: got %b required %b", c, obs_ready, exp_ready);
            end
            checks++;
            if (phase_tvalid !== exp_ptv || phase_tdata !== exp_ptd) begin
                errors++;
                $display("FAIL all4_issue cycle %0d: got %b/%h required %b/%h", c, phase_tvalid, phase_tdata,
                         exp_ptv, exp_ptd);
            end
            checks++;
            if (rsp_valid !== exp_rsp_valid || rsp_sin !== exp_rsp_sin || rsp_cos !== exp_rsp_cos) begin
                errors++;
                $display("FAIL all4_rsp cycle %0d: got %b/%h/%h required %b/%h/%h", c, rsp_valid, rsp_sin,
                         rsp_cos, exp_rsp_valid, exp_rsp_sin, exp_rsp_cos);
            end
            for (int i = 0; i < N; i++) begin
                if (obs_ready[i]) gq.push_back(i);
                if (rsp_valid[i]) rq.push_back(i);
            end
            if (c == 4) begin
                checks++;
                if (obs_ready !== '0 || sin_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL full_pop_no_grant: got ready=%b sin_v=%b required 0000/1", obs_ready, sin_tvalid);
                end
            end
            if (c == 5) begin
                checks++;
                if (obs_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL grant_after_pop: got %b required 0001", obs_ready);
                end
            end
        end
        checks++;
        if (gq.size() < 6) begin
            errors++;
            $display("FAIL all4_grant_count: got %0d required >=6", gq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                if (gq[k] != k % 4) begin
                    errors++;
                    $display("FAIL all4_grant_order pos %0d: got %0d required %0d", k, gq[k], k % 4);
                end
            end
        end
        checks++;
        if (rq.size() < 4) begin
            errors++;
            $display("FAIL all4_rsp_count: got %0d required >=4", rq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (rq[k] != k) begin
                    errors++;
                    $display("FAIL all4_rsp_order pos %0d: got %0d required %0d", k, rq[k], k);
                end
            end
        end
    endtask

    task automatic test_orphan();
        do_reset();
        sin_tdata  = $urandom;
        cos_tdata  = $urandom;
        sin_tvalid = 1'b1;
        cos_tvalid = 1'b1;
        cycle();
        sin_tvalid = 1'b0;
        cos_tvalid = 1'b0;
        checks++;
        if (rsp_valid !== '0 || err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set: got rsp=%b orphan=%b required 0000/1", rsp_valid, err_orphan);
        end
        for (int c = 0; c < 5; c++) cycle();
        checks++;
        if (err_orphan !== 1'b1 || rsp_valid !== '0 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL orphan_sticky: got orphan=%b rsp=%b busy=%b required 1/0000/0", err_orphan,
                     rsp_valid, obs_busy);
        end
        do_reset();
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_clear: got %b required 0", err_orphan);
        end
    endtask

    task automatic test_mismatch();
        logic [DW-1:0] s;
        do_reset();
        arb_en = 1'b1;
        cycle();
        rand_phases();
        req_valid = 4'b0001;
        cycle();
        req_valid  = '0;
        sin_tvalid = 1'b1;
        cos_tvalid = 1'b0;
        sin_tdata  = $urandom;
        cycle();
        sin_tvalid = 1'b0;
        checks++;
        if (err_mismatch !== 1'b1 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL mismatch_set: got mm=%b rsp=%b required 1/0000", err_mismatch, rsp_valid);
        end
        s          = $urandom;
        sin_tdata  = s;
        cos_tdata  = ~s;
        sin_tvalid = 1'b1;
        cos_tvalid = 1'b1;
        cycle();
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_sin !== s || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_entry_kept: got rsp=%b sin=%h orphan=%b required 0001/%h/0", rsp_valid,
                     rsp_sin, err_orphan, s);
        end
        cycle();
        sin_tvalid = 1'b0;
        cos_tvalid = 1'b0;
        checks++;
        if (err_orphan !== 1'b1 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL mismatch_count_exact: got orphan=%b rsp=%b required 1/0000", err_orphan, rsp_valid);
        end
    endtask

    task automatic test_drain();
        int rsp_n, drain_n, last_rsp, drain_at;
        rsp_n = 0; drain_n = 0; last_rsp = -10; drain_at = -20;
        do_reset();
        cordic_on = 1'b1;
        arb_en    = 1'b1;
        cycle();
        req_valid = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            rand_phases();
            cycle();
            checks++;
            if (obs_ready !== exp_ready || obs_ready === '0) begin
                errors++;
                $display("FAIL drain_setup_grant %0d: got %b required %b", c, obs_ready, exp_ready);
            end
        end
        req_valid = '0;
        arb_en    = 1'b0;
        cycle();
        req_valid = '1;
        for (int c = 0; c < 15; c++) begin
            cycle();
            checks++;
            if (obs_ready !== '0) begin
                errors++;
                $display("FAIL drain_ready cycle %0d: got %b required 0000", c, obs_ready);
            end
            checks++;
            if (obs_drain !== exp_drain || rsp_valid !== exp_rsp_valid) begin
                errors++;
                $display("FAIL drain_step cycle %0d: got dd=%b rsp=%b required %b/%b", c, obs_drain, rsp_valid,
                         exp_drain, exp_rsp_valid);
            end
            if (rsp_valid !== '0) begin rsp_n++; last_rsp = c; end
            if (obs_drain === 1'b1) begin drain_n++; drain_at = c; end
        end
        checks++;
        if (rsp_n != 3 || drain_n != 1 || drain_at != last_rsp + 1) begin
            errors++;
            $display("FAIL drain_summary: got rsp=%0d pulses=%0d at=%0d last_rsp=%0d required 3/1/last+1",
                     rsp_n, drain_n, drain_at, last_rsp);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_random();
        do_reset();
        cordic_on = 1'b1;
        arb_en    = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) arb_en = ~arb_en;
            req_valid = 4'($urandom_range(0, 15));
            rand_phases();
            cycle();
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready cycle %0d: got %b required %b", c, obs_ready, exp_ready);
            end
            checks++;
            if (phase_tvalid !== exp_ptv || phase_tdata !== exp_ptd) begin
                errors++;
                $display("FAIL rand_issue cycle %0d: got %b/%h required %b/%h", c, phase_tvalid, phase_tdata,
                         exp_ptv, exp_ptd);
            end
            checks++;
            if (rsp_valid !== exp_rsp_valid || rsp_sin !== exp_rsp_sin || rsp_cos !== exp_rsp_cos) begin
                errors++;
                $display("FAIL rand_rsp cycle %0d: got %b/%h/%h required %b/%h/%h", c, rsp_valid, rsp_sin,
                         rsp_cos, exp_rsp_valid, exp_rsp_sin, exp_rsp_cos);
            end
            checks++;
            if ({obs_busy, obs_drain, err_orphan, err_mismatch} !== {exp_busy, exp_drain, exp_orphan, exp_mismatch}) begin
                errors++;
                $display("FAIL rand_status cycle %0d: got %b required %b", c,
                         {obs_busy, obs_drain, err_orphan, err_mismatch},
                         {exp_busy, exp_drain, exp_orphan, exp_mismatch});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_orphan();
        test_mismatch();
        test_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cordic_share_arbiter.md
Name: cordic_share_arbiter

Overview:
- Shares one sin/cos CORDIC core (AXI-stream phase in, sin/cos out, no backpressure) between N_REQ joint-calculation requesters.
- Each request is granted round-robin and its phase is issued to the core. The requester index is tracked in an in-order tag FIFO, and each sin/cos result is routed back to the requester that issued it.
- Sits between the per-joint kinematics sequencers and the shared CORDIC IP.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_OUT, 4, max in-flight CORDIC ops; tag FIFO depth; power of 2.
- DATA_W, 32, width of phase, sin and cos words.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- arb_en  in  1  level; 1 = grant requests, 0 = stop granting and drain.
- req_valid  in  N_REQ  per-requester request.
- req_phase  in  N_REQ*DATA_W  requester i's phase in bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  combinational one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- phase_tdata  out  DATA_W  to CORDIC.
- phase_tvalid  out  1  to CORDIC.
- sin_tdata  in  DATA_W  from CORDIC.
- sin_tvalid  in  1  from CORDIC.
- cos_tdata  in  DATA_W  from CORDIC.
- cos_tvalid  in  1  from CORDIC.
- rsp_valid  out  N_REQ  one-hot, 1-cycle pulse to the owning requester.
- rsp_sin  out  DATA_W  result sin, valid with rsp_valid.
- rsp_cos  out  DATA_W  result cos, valid with rsp_valid.
- busy  out  1  state != IDLE or outstanding count != 0.
- drain_done  out  1  1-cycle pulse on DRAIN->IDLE.
- err_orphan  out  1  sticky; result arrived while tag FIFO empty.
- err_mismatch  out  1  sticky; sin_tvalid != cos_tvalid in some cycle.

Behaviour:
- Reset: all outputs 0; state IDLE; tag FIFO empty; outstanding count 0; rr_ptr 0.
- FSM transitions:
  - IDLE -> RUN when arb_en=1.
  - RUN -> DRAIN when arb_en=0.
  - DRAIN -> RUN when arb_en=1.
  - DRAIN -> IDLE when count=0 and no result arrives that cycle; drain_done pulses 1 cycle on this transition.
  - Grants are issued only in RUN.
- Grant condition: state=RUN, count<MAX_OUT, and any req_valid is set.
  - Winner is the first set req_valid at index >= rr_ptr, wrapping modulo N_REQ.
  - req_ready[winner]=1 that cycle; all other req_ready bits are 0.
  - rr_ptr <= (winner+1) mod N_REQ.
  - A result pop in the same cycle does NOT free a slot for that cycle's grant; capacity is judged on the pre-cycle count.
- Issue latency: 1 cycle.
  - The cycle after a grant: phase_tvalid=1 for exactly 1 cycle, phase_tdata=winner's phase.
  - Otherwise phase_tvalid=0 and phase_tdata holds its last value.
  - The winner's tag is pushed into the FIFO in the grant cycle.
- Back-to-back grants on consecutive cycles are allowed; throughput is 1 op/cycle.
- Result routing: when sin_tvalid and cos_tvalid are both 1 and the FIFO is non-empty:
  - pop the head tag;
  - next cycle, rsp_valid=onehot(tag) and rsp_sin/rsp_cos = the captured data;
  - response latency is 1 cycle; rsp_valid is 0 otherwise.
- Simultaneous push and pop: count unchanged, FIFO pointers both advance. Count range is 0..MAX_OUT; pointers wrap modulo MAX_OUT.
- Result with FIFO empty: data dropped, no rsp_valid, err_orphan set.
- sin_tvalid XOR cos_tvalid in a cycle: err_mismatch set; no pop, no response.
- Both error flags clear only on rst.
- arb_en deasserted mid-stream:
  - no new grants from the next cycle;
  - in-flight results are still routed;
  - a grant in the same cycle arb_en falls is still honoured, because state was RUN.
- rst mid-operation: FIFO flushed; results arriving afterwards count as orphans.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest set req_valid index wins; rr_ptr is not implemented.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single request: RUN, req_valid=4'b0100, phase 0x2000_0000; CORDIC model with 3-cycle latency.
  -> req_ready=4'b0100 in the grant cycle; phase_tvalid 1 cycle later with 0x2000_0000; rsp_valid=4'b0100 one cycle after sin/cos valid, carrying the model's sin/cos.
- All 4 requesting continuously from reset.
  -> grant order 0,1,2,3,0,1...; phase_tvalid high 4 consecutive cycles; then stall at count=4 until the first result; responses in the same order.
- MAX_OUT=4 full plus result pop in the same cycle as a pending request.
  -> no grant that cycle; grant next cycle; count never exceeds 4.
- sin/cos valid pulse with no ops outstanding.
  -> no rsp_valid; err_orphan=1 held until rst.
- sin_tvalid=1, cos_tvalid=0 for one cycle.
  -> err_mismatch=1; FIFO count unchanged.
- 3 ops in flight, then drop arb_en.
  -> no further req_ready; 3 responses delivered; drain_done pulses once after the 3rd result; busy falls to 0.
